// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: ALU commands,
// opcode/funct values, datapath mux selects and the sequencer state set.
package control_defs;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_R31 = 2'd2;

    localparam logic [1:0] WBS_ALU = 2'd0;
    localparam logic [1:0] WBS_MEM = 2'd1;
    localparam logic [1:0] WBS_PC4 = 2'd2;

    typedef enum logic [3:0] {
        ST_FETCH, ST_DECODE, ST_ADDR, ST_MEM_RD, ST_MEM_WR, ST_WB_MEM,
        ST_EXEC_R, ST_WB_R, ST_EXEC_I, ST_WB_I, ST_BRANCH, ST_TRAP
    } state_e;

    // Jumps complete inside DECODE, so they go straight back to FETCH.
    function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_e s;
        s = ST_TRAP;
        case (op)
            OP_RTYPE: begin
                if (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT) s = ST_EXEC_R;
                else if (fn == FN_JR) s = ST_FETCH;
            end
            OP_J, OP_JAL:    s = ST_FETCH;
            OP_BNE:          s = ST_BRANCH;
            OP_LW, OP_SW:    s = ST_ADDR;
            OP_ADDI, OP_XORI: s = ST_EXEC_I;
            default:         s = ST_TRAP;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] r_command(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] i_command(input logic [5:0] op);
        return (op == OP_XORI) ? ALU_XOR : ALU_ADD;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles a memory request has been waiting; flags the cycle in which
// the wait reaches the timeout limit.
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic waiting_i,
    input  logic ready_i,
    output logic expired_o
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i || ready_i) cnt_d = '0;
        else if (waiting_i)     cnt_d = cnt_q + TMO_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // This waiting cycle is the one that brings the count up to the limit.
    assign expired_o = waiting_i && (cnt_q == TMO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-subset datapath: walks each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath strobes.
module multicycle_control
    import control_defs::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memReady,
    output logic       memReq,
    output logic       memWrite,
    output logic       iorD,
    output logic       irWrite,
    output logic       pcWrite,
    output logic [1:0] pcSource,
    output logic       writeReg,
    output logic [1:0] regDest,
    output logic [1:0] wbSource,
    output logic       ALUoperandSource,
    output logic [2:0] command,
    output logic       fault,
    output logic       retired
);

    state_e state_q, state_d;
    logic   wd_start, wd_expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (memReady)        state_d = ST_DECODE;
                else if (wd_expired) state_d = ST_TRAP;
            end
            ST_DECODE: state_d = decode_next(opcode, funct);
            ST_EXEC_R: state_d = ST_WB_R;
            ST_EXEC_I: state_d = ST_WB_I;
            ST_ADDR:   state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (memReady)        state_d = ST_WB_MEM;
                else if (wd_expired) state_d = ST_TRAP;
            end
            ST_MEM_WR: begin
                if (memReady)        state_d = ST_FETCH;
                else if (wd_expired) state_d = ST_TRAP;
            end
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH: state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_TRAP;
        endcase
    end

    // Outputs are forced low for as long as reset is held, not just after the edge.
    always_comb begin
        memReq           = 1'b0;
        memWrite         = 1'b0;
        iorD             = 1'b0;
        irWrite          = 1'b0;
        pcWrite          = 1'b0;
        pcSource         = PC_PLUS4;
        writeReg         = 1'b0;
        regDest          = RD_RT;
        wbSource         = WBS_ALU;
        ALUoperandSource = 1'b0;
        command          = ALU_ADD;
        fault            = 1'b0;
        retired          = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    memReq  = 1'b1;
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                ST_DECODE: begin
                    if (opcode == OP_J || opcode == OP_JAL) begin
                        pcWrite  = 1'b1;
                        pcSource = PC_JUMP;
                        retired  = 1'b1;
                    end
                    if (opcode == OP_JAL) begin
                        writeReg = 1'b1;
                        regDest  = RD_R31;
                        wbSource = WBS_PC4;
                    end
                    if (opcode == OP_RTYPE && funct == FN_JR) begin
                        pcWrite  = 1'b1;
                        pcSource = PC_REG;
                        retired  = 1'b1;
                    end
                end
                ST_EXEC_R: command = r_command(funct);
                ST_EXEC_I: begin
                    ALUoperandSource = 1'b1;
                    command          = i_command(opcode);
                end
                ST_WB_R: begin
                    writeReg = 1'b1;
                    regDest  = RD_RD;
                    retired  = 1'b1;
                end
                ST_WB_I: begin
                    writeReg = 1'b1;
                    retired  = 1'b1;
                end
                ST_BRANCH: begin
                    command  = ALU_SUB;
                    pcSource = PC_BRANCH;
                    pcWrite  = ~zero;
                    retired  = 1'b1;
                end
                ST_ADDR: ALUoperandSource = 1'b1;
                ST_MEM_RD: begin
                    memReq = 1'b1;
                    iorD   = 1'b1;
                end
                ST_MEM_WR: begin
                    memReq   = 1'b1;
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                    retired  = memReady;
                end
                ST_WB_MEM: begin
                    writeReg = 1'b1;
                    wbSource = WBS_MEM;
                    retired  = 1'b1;
                end
                ST_TRAP: fault = 1'b1;
                default: fault = 1'b1;
            endcase
        end
    end

    assign wd_start = (state_d != state_q) &&
                      (state_d == ST_FETCH || state_d == ST_MEM_RD || state_d == ST_MEM_WR);

    mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMO_W      (TMO_W)
    ) u_watchdog (
        .clk_i    (clk),
        .rst_i    (reset),
        .start_i  (wd_start),
        .waiting_i(memReq && !memReady),
        .ready_i  (memReady),
        .expired_o(wd_expired)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected strobe traces queued from an
// instruction table, plus hand-built timeout, trap and reset sequences.
module tb_multicycle_control;

    typedef struct packed {
        logic       memReq;
        logic       memWrite;
        logic       iorD;
        logic       irWrite;
        logic       pcWrite;
        logic [1:0] pcSource;
        logic       writeReg;
        logic [1:0] regDest;
        logic [1:0] wbSource;
        logic       aluSrc;
        logic [2:0] command;
        logic       fault;
        logic       retired;
    } outs_t;

    typedef struct {
        logic  rdy;
        outs_t exp;
    } trace_t;

    typedef struct {
        string      nm;
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        int         fwait;
        int         mwait;
        int         cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       memReady = 1'b0;
    logic       memReq, memWrite, iorD, irWrite, pcWrite, writeReg;
    logic       ALUoperandSource, fault, retired;
    logic [1:0] pcSource, regDest, wbSource;
    logic [2:0] command;

    int     n_checks = 0;
    int     n_fail = 0;
    trace_t q[$];
    vec_t   vecs[15];

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(16), .TMO_W(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .memReady(memReady), .memReq(memReq), .memWrite(memWrite), .iorD(iorD),
        .irWrite(irWrite), .pcWrite(pcWrite), .pcSource(pcSource),
        .writeReg(writeReg), .regDest(regDest), .wbSource(wbSource),
        .ALUoperandSource(ALUoperandSource), .command(command), .fault(fault),
        .retired(retired)
    );

    function automatic outs_t actual();
        outs_t a;
        a = '{memReq, memWrite, iorD, irWrite, pcWrite, pcSource, writeReg,
              regDest, wbSource, ALUoperandSource, command, fault, retired};
        return a;
    endfunction

    task automatic check_now(input outs_t e, input string nm, input int cyc);
        outs_t a;
        a = actual();
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s cycle %0d: outputs got %h expected %h", nm, cyc, a, e);
        end
    endtask

    task automatic check_int(input int got, input int exp, input string nm);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic push(input logic rdy, input outs_t e);
        trace_t t;
        t.rdy = rdy;
        t.exp = e;
        q.push_back(t);
    endtask

    function automatic outs_t fetch_o(input logic rdy);
        outs_t o;
        o = '0;
        o.memReq = 1'b1;
        o.irWrite = rdy;
        o.pcWrite = rdy;
        return o;
    endfunction

    function automatic outs_t trap_o();
        outs_t o;
        o = '0;
        o.fault = 1'b1;
        return o;
    endfunction

    // Applies queued cycles; exp_ret > 0 also checks the cycle on which retired first fires.
    task automatic run_queue(input string nm, input int exp_ret);
        trace_t t;
        int idx;
        int ret_at;
        idx = 0;
        ret_at = -1;
        while (q.size() > 0) begin
            t = q.pop_front();
            memReady = t.rdy;
            @(negedge clk);
            check_now(t.exp, nm, idx + 1);
            if (retired === 1'b1 && ret_at < 0) ret_at = idx + 1;
            idx++;
            @(posedge clk);
            #1;
        end
        memReady = 1'b0;
        if (exp_ret > 0) check_int(ret_at, exp_ret, {nm, " retire cycle"});
    endtask

    task automatic gen_trace(input vec_t v);
        outs_t o;
        for (int i = 0; i < v.fwait; i++) push(1'b0, fetch_o(1'b0));
        push(1'b1, fetch_o(1'b1));
        o = '0;
        case (v.op)
            6'h00: begin
                if (v.fn == 6'h08) begin
                    o.pcWrite = 1'b1; o.pcSource = 2'd3; o.retired = 1'b1;
                    push(1'b0, o);
                end else begin
                    push(1'b0, o);
                    o.command = (v.fn == 6'h20) ? 3'b000 : (v.fn == 6'h22) ? 3'b001 : 3'b010;
                    push(1'b0, o);
                    o = '0; o.writeReg = 1'b1; o.regDest = 2'd1; o.retired = 1'b1;
                    push(1'b0, o);
                end
            end
            6'h02, 6'h03: begin
                o.pcWrite = 1'b1; o.pcSource = 2'd2; o.retired = 1'b1;
                if (v.op == 6'h03) begin
                    o.writeReg = 1'b1; o.regDest = 2'd2; o.wbSource = 2'd2;
                end
                push(1'b0, o);
            end
            6'h05: begin
                push(1'b0, o);
                o.command = 3'b001; o.pcSource = 2'd1; o.pcWrite = ~v.zero; o.retired = 1'b1;
                push(1'b0, o);
            end
            6'h08, 6'h0e: begin
                push(1'b0, o);
                o.aluSrc = 1'b1; o.command = (v.op == 6'h0e) ? 3'b011 : 3'b000;
                push(1'b0, o);
                o = '0; o.writeReg = 1'b1; o.retired = 1'b1;
                push(1'b0, o);
            end
            default: begin
                push(1'b0, o);
                o.aluSrc = 1'b1;
                push(1'b0, o);
                o = '0; o.memReq = 1'b1; o.iorD = 1'b1; o.memWrite = (v.op == 6'h2b);
                for (int i = 0; i < v.mwait; i++) push(1'b0, o);
                o.retired = (v.op == 6'h2b);
                push(1'b1, o);
                if (v.op == 6'h23) begin
                    o = '0; o.writeReg = 1'b1; o.wbSource = 2'd1; o.retired = 1'b1;
                    push(1'b0, o);
                end
            end
        endcase
    endtask

    task automatic pulse_reset(input string nm);
        reset = 1'b1;
        memReady = 1'b0;
        #2;
        check_now('0, {nm, " in reset"}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_now(fetch_o(1'b0), {nm, " after release"}, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        outs_t o;
        vecs[0]  = '{"ADD",      6'h00, 6'h20, 1'b0, 0,  0,  4};
        vecs[1]  = '{"SUB",      6'h00, 6'h22, 1'b0, 2,  0,  6};
        vecs[2]  = '{"SLT",      6'h00, 6'h2a, 1'b0, 0,  0,  4};
        vecs[3]  = '{"ADDI",     6'h08, 6'h15, 1'b0, 0,  0,  4};
        vecs[4]  = '{"XORI",     6'h0e, 6'h3f, 1'b0, 1,  0,  5};
        vecs[5]  = '{"BNE z0",   6'h05, 6'h00, 1'b0, 0,  0,  3};
        vecs[6]  = '{"BNE z1",   6'h05, 6'h00, 1'b1, 0,  0,  3};
        vecs[7]  = '{"LW w3",    6'h23, 6'h00, 1'b0, 0,  3,  8};
        vecs[8]  = '{"SW",       6'h2b, 6'h00, 1'b0, 0,  0,  4};
        vecs[9]  = '{"SW w2",    6'h2b, 6'h00, 1'b0, 1,  2,  7};
        vecs[10] = '{"J",        6'h02, 6'h11, 1'b0, 0,  0,  2};
        vecs[11] = '{"JR",       6'h00, 6'h08, 1'b0, 0,  0,  2};
        vecs[12] = '{"JAL",      6'h03, 6'h00, 1'b0, 0,  0,  2};
        vecs[13] = '{"ADD f15",  6'h00, 6'h20, 1'b0, 15, 0,  19};
        vecs[14] = '{"LW w15",   6'h23, 6'h00, 1'b0, 0,  15, 20};

        #12;
        check_now('0, "reset held", 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            opcode = vecs[i].op;
            funct  = vecs[i].fn;
            zero   = vecs[i].zero;
            gen_trace(vecs[i]);
            run_queue(vecs[i].nm, vecs[i].cyc);
        end

        // Fetch never acknowledged: 16 request cycles, then trap that ignores memReady.
        opcode = 6'h00; funct = 6'h20;
        for (int i = 0; i < 16; i++) push(1'b0, fetch_o(1'b0));
        push(1'b0, trap_o());
        push(1'b1, trap_o());
        push(1'b0, trap_o());
        run_queue("fetch timeout", 0);
        pulse_reset("timeout reset");

        // Load whose data phase never completes.
        opcode = 6'h23;
        push(1'b1, fetch_o(1'b1));
        push(1'b0, '0);
        o = '0; o.aluSrc = 1'b1;
        push(1'b0, o);
        o = '0; o.memReq = 1'b1; o.iorD = 1'b1;
        for (int i = 0; i < 16; i++) push(1'b0, o);
        push(1'b0, trap_o());
        run_queue("LW timeout", 0);
        pulse_reset("LW timeout reset");

        // Illegal opcode and illegal R-type funct both trap without strobes.
        opcode = 6'h3f; funct = 6'h20;
        push(1'b1, fetch_o(1'b1));
        push(1'b0, '0);
        for (int i = 0; i < 4; i++) push(1'b0, trap_o());
        run_queue("illegal op", 0);
        pulse_reset("illegal op reset");

        opcode = 6'h00; funct = 6'h21;
        push(1'b1, fetch_o(1'b1));
        push(1'b0, '0);
        push(1'b0, trap_o());
        push(1'b1, trap_o());
        run_queue("illegal funct", 0);
        pulse_reset("illegal funct reset");

        // Asynchronous reset in the middle of a store wait.
        opcode = 6'h2b; funct = 6'h00;
        push(1'b1, fetch_o(1'b1));
        push(1'b0, '0);
        o = '0; o.aluSrc = 1'b1;
        push(1'b0, o);
        o = '0; o.memReq = 1'b1; o.iorD = 1'b1; o.memWrite = 1'b1;
        push(1'b0, o);
        run_queue("SW before reset", 0);
        #2;
        check_now(o, "SW waiting", 0);
        reset = 1'b1;
        #1;
        check_now('0, "SW async reset", 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_now(fetch_o(1'b0), "SW reset release", 1);
        @(posedge clk);
        #1;

        // Normal operation resumes after the aborted store.
        opcode = 6'h00; funct = 6'h22;
        gen_trace(vecs[1]);
        run_queue("SUB after reset", 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
